fft_sample_loader: RTL and testbench
====================================

// Module: fft_sample_loader
// PURPOSE
//   Input stage of the FFT datapath. Accepts a stream of real audio samples over a valid/ready
//   handshake and packs each one as a complex word {re=sample, im=0}. Writes the words into the
//   FFT working RAM at bit-reversed addresses, so the in-place radix-2 engine can start directly.
//   Holds off new samples until the engine reports the frame consumed.
// PARAMETERS
//   width    16   bits per real/imag component (signed fixed point)
//   M        5    log2 of FFT length; N = 2**M points per frame
//   DROP_W   8    width of saturating dropped-sample counter
// PORTS
//   clk            in   1         system clock; all state updates on rising edge
//   reset          in   1         synchronous, active-low reset
//   sample_in      in   width     incoming real sample
//   sample_valid   in   1         sample_in valid this cycle
//   sample_ready   out  1         loader can accept a sample this cycle
//   wr_en          out  1         RAM write strobe (registered)
//   wr_addr        out  M         RAM write address = bit_reverse(sample index)
//   wr_data        out  2*width   {re, im}; im always 0
//   load_done      out  1         one-cycle pulse: full frame written
//   fft_done       in   1         engine finished with current frame; buffer free
//   frame_ready    out  1         level: frame held in RAM, engine may run
//   dropped        out  DROP_W    saturating count of valid samples refused while holding
// BEHAVIOUR
//   - FSM states: FILL (accepting), HOLD (frame complete, waiting for engine).
//   - Reset (reset==0 at edge): state=FILL, idx=0, wr_en=0, wr_addr=0, wr_data=0, load_done=0,
//     frame_ready=0, dropped=0. Reset mid-frame discards partial frame; RAM contents are not cleared.
//   - sample_ready = (state==FILL), combinational from state; sample_valid never gates it.
//   - Accept = sample_valid & sample_ready. On accept at edge k: at edge k+1 wr_en=1,
//     wr_addr=bit_reverse(idx), wr_data={sample_in, width'(0)}; idx increments. Latency 1 cycle.
//   - No accept in a cycle -> wr_en=0 next cycle; wr_addr/wr_data hold their last values.
//   - Accept with idx==N-1: idx wraps to 0, state->HOLD. load_done=1 and frame_ready=1 in the
//     same cycle as that final wr_en.
//   - HOLD: sample_ready=0. Each sample_valid=1 cycle increments dropped, saturating at 2**DROP_W-1.
//   - HOLD & fft_done: state->FILL, frame_ready=0 next cycle; sample_ready=1 from that cycle on.
//   - fft_done while in FILL is ignored, with no effect on idx or outputs.
//   - fft_done in the same cycle the last sample is accepted is ignored. The FILL->HOLD transition
//     wins, so the engine must pulse fft_done again after load_done.
//   - dropped is cleared only by reset.
// CONFIGURATION
//   - Macro FFT_LOADER_UNSIGNED_IN_EN.
//   - Defined: sample_in is offset-binary (unsigned ADC code). The loader inverts its MSB before
//     packing, so 16'h8000 -> 16'sh0000 and 16'h0000 -> 16'sh8000.
//   - Undefined: sample_in is already two's complement and is passed through unchanged.
// STRUCTURE
//   - Shared package fft_pkg: FFT_WIDTH, FFT_M, FFT_N constants; complex_t packed struct
//     {re, im}; loader_state_t enum {FILL, HOLD}.
//   - Sub-module: the existing parameterized bit_reverse #(M) maps idx -> wr_addr.
//     No other sub-modules.
// TESTING
//   - Reset then 32 back-to-back samples 0..31 (M=5): wr_addr sequence 0,16,8,24,4,...,31;
//     wr_data={k,16'h0}; load_done on 32nd write only.
//   - Valid toggling 1,0,1,0: wr_en follows with 1-cycle lag; idx advances only on accepts;
//     frame completes after 32 accepts.
//   - After frame, hold sample_valid=1 for 300 cycles with no fft_done: sample_ready=0,
//     dropped saturates at 255, no wr_en.
//   - fft_done pulse in HOLD: next cycle sample_ready=1, frame_ready=0; next frame starts at
//     wr_addr=0.
//   - Assert reset after 10 samples: all outputs 0 next cycle; next accepted sample writes
//     wr_addr=0.
//   - With FFT_LOADER_UNSIGNED_IN_EN: sample_in=16'h8000 -> wr_data[31:16]=16'h0000;
//     16'hFFFF -> 16'h7FFF.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath types and constants.
// Sized for a 32-point radix-2 engine with 16-bit components.
package fft_pkg;

  localparam int FFT_WIDTH = 16;
  localparam int FFT_M     = 5;
  localparam int FFT_N     = 1 << FFT_M;

  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } complex_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

endpackage

// File: rtl/fft_sample_loader_if.sv
// Real-sample stream into the FFT loader.
// Plain valid/ready handshake, one sample per accept.
interface fft_sample_loader_if #(
  parameter int W = 16
) ();

  logic [W-1:0] sample_in;
  logic         sample_valid;
  logic         sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/bit_reverse.sv
// Reverses the bit order of an M-bit index.
// Pure wiring; used for radix-2 in-place FFT addressing.
module bit_reverse #(
  parameter int M = 5
) (
  input  logic [M-1:0] idx_i,
  output logic [M-1:0] rev_o
);

  always_comb begin
    rev_o = '0;
    for (int i = 0; i < M; i++) begin
      rev_o[i] = idx_i[M-1-i];
    end
  end

endmodule

// File: rtl/fft_sample_loader.sv
// Packs real samples as {re, 0} into FFT RAM at bit-reversed addresses.
// FFT_LOADER_UNSIGNED_IN_EN: treat sample_in as offset-binary.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int width  = FFT_WIDTH,
  parameter int M      = FFT_M,
  parameter int DROP_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_sample_loader_if.slave   s_if,
  output logic                 wr_en,
  output logic [M-1:0]         wr_addr,
  output logic [2*width-1:0]   wr_data,
  output logic                 load_done,
  input  logic                 fft_done,
  output logic                 frame_ready,
  output logic [DROP_W-1:0]    dropped
);

  localparam logic [M-1:0]      IDX_LAST = {M{1'b1}};
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  loader_state_t        state_q, state_d;
  logic [M-1:0]         idx_q, idx_d;
  logic                 wr_en_q, wr_en_d;
  logic [M-1:0]         wr_addr_q, wr_addr_d;
  logic [2*width-1:0]   wr_data_q, wr_data_d;
  logic                 load_done_q, load_done_d;
  logic                 frame_ready_q, frame_ready_d;
  logic [DROP_W-1:0]    dropped_q, dropped_d;

  logic [M-1:0]         rev_idx;
  logic [width-1:0]     re_pk;
  logic                 accept;

  bit_reverse #(
    .M (M)
  ) u_rev (
    .idx_i (idx_q),
    .rev_o (rev_idx)
  );

`ifdef FFT_LOADER_UNSIGNED_IN_EN
  // Offset-binary to two's complement: flip the MSB.
  assign re_pk = {~s_if.sample_in[width-1],
                  s_if.sample_in[width-2:0]};
`else
  assign re_pk = s_if.sample_in;
`endif

  assign s_if.sample_ready = (state_q == FILL);
  assign accept = s_if.sample_valid & s_if.sample_ready;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    load_done_d   = 1'b0;
    frame_ready_d = frame_ready_q;
    dropped_d     = dropped_q;

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = rev_idx;
      wr_data_d = {re_pk, {width{1'b0}}};
      idx_d     = idx_q + 1'b1;
      // Last sample wins over a coincident fft_done.
      if (idx_q == IDX_LAST) begin
        state_d       = HOLD;
        load_done_d   = 1'b1;
        frame_ready_d = 1'b1;
      end
    end else if (state_q == HOLD) begin
      if (s_if.sample_valid && dropped_q != DROP_MAX) begin
        dropped_d = dropped_q + 1'b1;
      end
      if (fft_done) begin
        state_d       = FILL;
        frame_ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= FILL;
      idx_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      load_done_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      dropped_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      load_done_q   <= load_done_d;
      frame_ready_q <= frame_ready_d;
      dropped_q     <= dropped_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign load_done   = load_done_q;
  assign frame_ready = frame_ready_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Bench for fft_sample_loader: vector table, directed
// frame sequences and random traffic against a frame model.
module tb_fft_sample_loader;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        load_done;
  logic        fft_done;
  logic        frame_ready;
  logic [7:0]  dropped;

  fft_sample_loader_if #(.W(16)) s_if ();

  fft_sample_loader #(
    .width  (16),
    .M      (5),
    .DROP_W (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_if        (s_if),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .load_done   (load_done),
    .fft_done    (fft_done),
    .frame_ready (frame_ready),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit       m_hold;
  int       m_cnt;
  int       m_drop;
  bit       m_wr_en;
  int       m_addr;
  complex_t m_word;
  bit       m_ld;
  bit       m_frame;

  function automatic int rev5(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  function automatic logic [15:0] pk(input logic [15:0] d);
`ifdef FFT_LOADER_UNSIGNED_IN_EN
    return d ^ 16'h8000;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_cnt = 0; m_drop = 0;
    m_wr_en = 0; m_addr = 0; m_word = '0;
    m_ld = 0; m_frame = 0;
  endtask

  task automatic tick(input logic v, input logic [15:0] d,
                      input logic fd, input logic rn);
    bit acc;
    s_if.sample_valid = v;
    s_if.sample_in    = d;
    fft_done          = fd;
    reset             = rn;
    if (!rn) model_reset();
    else begin
      acc = v && !m_hold;
      m_wr_en = acc;
      m_ld = 0;
      if (acc) begin
        m_addr = rev5(m_cnt);
        m_word.re = pk(d);
        m_word.im = '0;
        if (m_cnt == FFT_N - 1) begin
          m_cnt = 0; m_hold = 1; m_ld = 1; m_frame = 1;
        end else m_cnt++;
      end else if (m_hold) begin
        if (v && m_drop < 255) m_drop++;
        if (fd) begin m_hold = 0; m_frame = 0; end
      end
    end
    @(posedge clk);
    #1;
    chk("wr_en", 32'(wr_en), 32'(m_wr_en));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", wr_data, m_word);
    chk("load_done", 32'(load_done), 32'(m_ld));
    chk("frame_ready", 32'(frame_ready), 32'(m_frame));
    chk("dropped", 32'(dropped), 32'(m_drop));
    chk("ready", 32'(s_if.sample_ready), 32'(!m_hold));
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        fd;
    logic        e_wr_en;
    logic [4:0]  e_addr;
    logic [15:0] e_re;
    logic        e_ready;
  } vec_t;

  vec_t tbl[6];
  int   ld_cnt;

  initial begin
    s_if.sample_valid = 0;
    s_if.sample_in = '0;
    fft_done = 0;
    reset = 0;

    tbl[0] = '{1, 16'h1234, 0, 1, 5'd0,  pk(16'h1234), 1};
    tbl[1] = '{0, 16'hAAAA, 0, 0, 5'd0,  pk(16'h1234), 1};
    tbl[2] = '{1, 16'h8001, 1, 1, 5'd16, pk(16'h8001), 1};
    tbl[3] = '{1, 16'h7FFF, 0, 1, 5'd8,  pk(16'h7FFF), 1};
    tbl[4] = '{0, 16'h0000, 1, 0, 5'd8,  pk(16'h7FFF), 1};
    tbl[5] = '{1, 16'h0003, 0, 1, 5'd24, pk(16'h0003), 1};

    // Reset state
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_ready", 32'(s_if.sample_ready), 32'h1);

    for (int i = 0; i < 6; i++) begin
      tick(tbl[i].v, tbl[i].d, tbl[i].fd, 1);
      chk("tbl_wr_en", 32'(wr_en), 32'(tbl[i].e_wr_en));
      chk("tbl_addr", 32'(wr_addr), 32'(tbl[i].e_addr));
      chk("tbl_re", 32'(wr_data[31:16]), 32'(tbl[i].e_re));
      chk("tbl_im", 32'(wr_data[15:0]), 32'h0);
      chk("tbl_ready", 32'(s_if.sample_ready),
          32'(tbl[i].e_ready));
    end

    // Back-to-back frame 0..31
    tick(0, 0, 0, 0);
    ld_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      tick(1, 16'(k), 0, 1);
      chk("seq_addr", 32'(wr_addr), 32'(rev5(k)));
      chk("seq_data", wr_data, {16'(pk(16'(k))), 16'h0});
      if (load_done) ld_cnt++;
    end
    chk("seq_load_done_last", 32'(load_done), 32'h1);
    chk("seq_load_done_cnt", 32'(ld_cnt), 32'h1);
    chk("seq_frame_ready", 32'(frame_ready), 32'h1);

    // Hold with valid high: dropped saturates
    for (int i = 0; i < 300; i++) tick(1, 16'h5555, 0, 1);
    chk("sat_dropped", 32'(dropped), 32'd255);
    chk("sat_ready", 32'(s_if.sample_ready), 32'h0);

    // Release frame; next write starts at address 0
    tick(0, 0, 1, 1);
    chk("rel_ready", 32'(s_if.sample_ready), 32'h1);
    chk("rel_frame", 32'(frame_ready), 32'h0);
    tick(1, 16'h0101, 0, 1);
    chk("rel_addr", 32'(wr_addr), 32'h0);

    // Toggling valid; fft_done coincides with final accept
    for (int k = 1; k < 32; k++) begin
      tick(1, 16'(k * 3), (k == 31), 1);
      tick(0, 16'hDEAD, 0, 1);
      chk("tog_wr_en_low", 32'(wr_en), 32'h0);
    end
    chk("tog_still_hold", 32'(frame_ready), 32'h1);
    tick(0, 0, 1, 1);
    chk("tog_released", 32'(s_if.sample_ready), 32'h1);

    // Reset after 10 samples
    for (int k = 0; k < 10; k++) tick(1, 16'(k), 0, 1);
    tick(1, 16'h7777, 0, 0);
    chk("mid_rst_wr_en", 32'(wr_en), 32'h0);
    chk("mid_rst_data", wr_data, 32'h0);
    tick(1, 16'h4321, 0, 1);
    chk("mid_rst_addr", 32'(wr_addr), 32'h0);

    // MSB handling of sample_in
    tick(0, 0, 0, 0);
    tick(1, 16'h8000, 0, 1);
`ifdef FFT_LOADER_UNSIGNED_IN_EN
    chk("cfg_8000", 32'(wr_data[31:16]), 32'h0000);
`else
    chk("cfg_8000", 32'(wr_data[31:16]), 32'h8000);
`endif
    tick(1, 16'hFFFF, 0, 1);
`ifdef FFT_LOADER_UNSIGNED_IN_EN
    chk("cfg_ffff", 32'(wr_data[31:16]), 32'h7FFF);
`else
    chk("cfg_ffff", 32'(wr_data[31:16]), 32'hFFFF);
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 3) != 0,
           16'($urandom),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 399) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
